// File: rtl/inverse_pkg.sv
// Shared sizes, FSM state type and saturation helpers for the inverse checker.
package inverse_pkg;

  localparam int unsigned DW    = 20;
  localparam int unsigned N     = 5;
  localparam int unsigned NN    = N * N;
  localparam int unsigned ACC_W = 2 * DW + $clog2(N);
  localparam int unsigned IDX_W = $clog2(NN);
  localparam int unsigned RC_W  = $clog2(N);
  localparam int unsigned MC_W  = $clog2(NN + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_DET, MAC, EMIT, DONE
  } state_t;

  // True when the accumulator value is representable in DW signed bits.
  function automatic logic fits_dw(input logic signed [ACC_W-1:0] v);
    return (&v[ACC_W-1:DW-1]) | ~(|v[ACC_W-1:DW-1]);
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (fits_dw(v))       return v[DW-1:0];
    else if (v[ACC_W-1])  return {1'b1, {(DW-1){1'b0}}};
    else                  return {1'b0, {(DW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/inverse_check_mac_unit.sv
// Signed DW x DW multiply with a wide non-wrapping accumulator.
module mac_unit
  import inverse_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/inverse_check.sv
// Streams in A, B and det, computes P = A x B one MAC per cycle and checks P == det*I.
module inverse_check
  import inverse_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [MC_W-1:0] mismatch_cnt,
  output logic            ovf
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RC_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0]     det_q;
  logic [MC_W-1:0]   mcnt_q, mcnt_d;
  logic              ovf_q, ovf_d, pass_q, pass_d, fresh_q, fresh_d, en_q;
  logic [DW-1:0]     a_mem [NN];
  logic [DW-1:0]     b_mem [NN];

  logic              in_xfer, mac_en, mac_clr, mism;
  logic [IDX_W-1:0]  a_sel, b_sel;
  logic signed [ACC_W-1:0] acc, exp_val;

  // en_q keeps in_ready low until the first edge after reset release.
  assign in_ready = en_q && (state_q inside {IDLE, LOAD_A, LOAD_B, LOAD_DET});
  assign in_xfer  = in_valid && in_ready;
  assign a_sel    = IDX_W'(i_q * N + k_q);
  assign b_sel    = IDX_W'(k_q * N + j_q);

  mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_mem[a_sel]),
    .b_i   (b_mem[b_sel]),
    .acc_o (acc)
  );

  assign exp_val = (i_q == j_q) ? {{(ACC_W-DW){det_q[DW-1]}}, det_q} : '0;
  assign mism    = (acc != exp_val);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    mcnt_d  = mcnt_q;
    ovf_d   = ovf_q;
    pass_d  = pass_q;
    fresh_d = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    unique case (state_q)
      IDLE: if (in_xfer) begin
        idx_d   = IDX_W'(1);
        state_d = LOAD_A;
        mcnt_d  = '0;
        ovf_d   = 1'b0;
        pass_d  = 1'b0;
      end
      LOAD_A: if (in_xfer) begin
        if (idx_q == IDX_W'(NN-1)) begin
          idx_d   = '0;
          state_d = LOAD_B;
        end else idx_d = idx_q + 1'b1;
      end
      LOAD_B: if (in_xfer) begin
        if (idx_q == IDX_W'(NN-1)) begin
          idx_d   = '0;
          state_d = LOAD_DET;
        end else idx_d = idx_q + 1'b1;
      end
      LOAD_DET: if (in_xfer) begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        mac_clr = 1'b1;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == RC_W'(N-1)) begin
          k_d     = '0;
          fresh_d = 1'b1;
          state_d = EMIT;
        end else k_d = k_q + 1'b1;
      end
      EMIT: begin
        // Score each element once, on its first EMIT cycle, however long it stalls.
        if (fresh_q) begin
          if (mism)         mcnt_d = mcnt_q + 1'b1;
          if (!fits_dw(acc)) ovf_d = 1'b1;
        end
        if (out_ready) begin
          mac_clr = 1'b1;
          if (j_q == RC_W'(N-1)) begin
            j_d = '0;
            if (i_q == RC_W'(N-1)) begin
              i_d     = '0;
              pass_d  = (mcnt_d == '0);
              state_d = DONE;
            end else begin
              i_d     = i_q + 1'b1;
              state_d = MAC;
            end
          end else begin
            j_d     = j_q + 1'b1;
            state_d = MAC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      det_q   <= '0;
      mcnt_q  <= '0;
      ovf_q   <= 1'b0;
      pass_q  <= 1'b0;
      fresh_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mcnt_q  <= mcnt_d;
      ovf_q   <= ovf_d;
      pass_q  <= pass_d;
      fresh_q <= fresh_d;
      en_q    <= 1'b1;
      if (state_q == LOAD_DET && in_xfer) det_q <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && (state_q == IDLE || state_q == LOAD_A)) a_mem[idx_q] <= in_data;
    if (in_xfer && state_q == LOAD_B)                      b_mem[idx_q] <= in_data;
  end

  assign out_valid    = (state_q == EMIT);
  assign out_data     = (state_q == EMIT) ? sat(acc) : '0;
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign mismatch_cnt = mcnt_q;
  assign ovf          = ovf_q;

endmodule
